// File: rtl/instr_fetch_unit.sv
// Fetch/sequencing front end for the MIPS core: fetches over a req/ack imem
// handshake, presents op_code/funct to ctrl_unit and computes the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    output logic [31:0]      instr,
    output logic [5:0]       op_code,
    output logic [5:0]       funct,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_RST = RESET_PC & ~XLEN'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   instr_d;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic              req_q;
    logic              valid_q;

    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   jump_target;
    logic [XLEN-1:0]   branch_target;

    // Candidate next-PC values; all arithmetic wraps modulo 2^32.
    assign pc4           = pc_q + XLEN'(4);
    assign jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update; acks outside REQ fall through to defaults.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (jump) begin
                        pc_d = jump_target;
                    end else if (branch && zero) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = pc4;
                    end
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = run ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are flopped from the next state so they track state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= PC_RST;
            instr_q   <= '0;
            retired_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= (state_d == REQ);
            valid_q   <= (state_d == EXEC);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign retired     = retired_q;

endmodule
